// File: rtl/sram_controller_pkg.sv
// ----------------------------------------------------------------------------
// sram_controller_pkg : shared state encoding and defaults for the SRAM
//                       controller that serves MEM-stage loads and stores.
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package sram_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOW  = 3'd1,
    ST_HIGH = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam int unsigned       DEFAULT_ACCESS_CYCLES = 6;
  localparam logic [31:0]       DEFAULT_BASE_ADDR     = 32'd1024;
  localparam int unsigned       DEFAULT_SRAM_ADDR_W   = 18;

  // Byte offset of a CPU address inside the SRAM window (wraps mod 2^32).
  function automatic logic [31:0] sram_offset(input logic [31:0] addr,
                                              input logic [31:0] base);
    return addr - base;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_controller.sv
// ----------------------------------------------------------------------------
// sram_controller : splits each 32-bit load/store into two 16-bit SRAM cycles
//                   padded to ACCESS_CYCLES; ready low freezes the pipeline.
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = DEFAULT_ACCESS_CYCLES,
  parameter logic [31:0] BASE_ADDR     = DEFAULT_BASE_ADDR,
  parameter int unsigned SRAM_ADDR_W   = DEFAULT_SRAM_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  inout  wire  [15:0]            SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N
);

  localparam int unsigned WAIT_CYCLES = ACCESS_CYCLES - 4;
  localparam int unsigned CNT_W       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  state_t                 r_state;
  state_t                 w_state_next;
  logic                   r_is_write;
  logic [SRAM_ADDR_W-2:0] r_word;
  logic [31:0]            r_wdata;
  logic [31:0]            r_rbuf;
  logic [CNT_W-1:0]       r_cnt;

  logic [31:0]            w_off;
  logic                   w_req;
  logic                   w_drive;
  logic [15:0]            w_dq_out;
  logic                   w_unused;

  assign w_off    = sram_offset(address, BASE_ADDR);
  assign w_req    = rd_en | wr_en;
  assign w_unused = ^{w_off[31:SRAM_ADDR_W+1], w_off[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      read_data  <= '0;
      r_rbuf     <= '0;
      r_is_write <= 1'b0;
      r_word     <= '0;
      r_wdata    <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: begin
          // Only the copies taken here are used for the rest of the access.
          if (w_req) begin
            r_is_write <= wr_en;
            r_word     <= w_off[SRAM_ADDR_W:2];
            r_wdata    <= write_data;
          end
        end
        ST_LOW: begin
          if (!r_is_write) r_rbuf[15:0] <= SRAM_DQ;
        end
        ST_HIGH: begin
          if (!r_is_write) r_rbuf[31:16] <= SRAM_DQ;
          r_cnt <= '0;
        end
        ST_WAIT: r_cnt <= r_cnt + 1'b1;
        ST_DONE: begin
          if (!r_is_write) read_data <= r_rbuf;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_next = r_state;
    ready        = 1'b0;
    SRAM_ADDR    = '0;
    SRAM_WE_N    = 1'b1;
    SRAM_OE_N    = 1'b1;
    w_drive      = 1'b0;
    w_dq_out     = '0;
    case (r_state)
      ST_IDLE: begin
        ready = ~w_req;
        if (w_req) w_state_next = ST_LOW;
      end
      ST_LOW: begin
        SRAM_ADDR = {r_word, 1'b0};
        if (r_is_write) begin
          SRAM_WE_N = 1'b0;
          w_drive   = 1'b1;
          w_dq_out  = r_wdata[15:0];
        end else begin
          SRAM_OE_N = 1'b0;
        end
        w_state_next = ST_HIGH;
      end
      ST_HIGH: begin
        SRAM_ADDR = {r_word, 1'b1};
        if (r_is_write) begin
          SRAM_WE_N = 1'b0;
          w_drive   = 1'b1;
          w_dq_out  = r_wdata[31:16];
        end else begin
          SRAM_OE_N = 1'b0;
        end
        w_state_next = (ACCESS_CYCLES == 4) ? ST_DONE : ST_WAIT;
      end
      ST_WAIT: begin
        if (r_cnt == CNT_LAST) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        ready        = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign SRAM_DQ   = w_drive ? w_dq_out : 16'hzzzz;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

endmodule

`default_nettype wire
